adc_ltc2308_sampler: RTL and testbench



---
 rtl/adc_ltc2308_sampler.sv | 241 ++++++++++++++++++++++++
 tb/tb_adc_ltc2308_sampler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_ltc2308_sampler.sv
// LTC2308 SPI sampler: continuous single-channel conversions, raw sample
// output tagged with its channel, and a power-of-two block average.
module adc_ltc2308_sampler #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned CONV_CYCLES = 80,
  parameter int unsigned AVG_LOG2    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  channel,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo,
  output logic [11:0] sample,
  output logic [2:0]  sample_ch,
  output logic        sample_valid,
  output logic [11:0] adc_value,
  output logic        avg_valid,
  output logic        busy
);

  localparam int unsigned DATA_W    = 12;
  localparam int unsigned CH_W      = 3;
  localparam int unsigned BIT_W     = 4;
  localparam int unsigned ACC_W     = DATA_W + AVG_LOG2;
  localparam int unsigned AVG_N     = 1 << AVG_LOG2;
  localparam int unsigned AVG_CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CONV_W    = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CONV_W-1:0]    conv_cnt_q, conv_cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 phase_q, phase_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0]    shreg_q, shreg_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [CH_W-1:0]      tag_ch_q, tag_ch_d;
  logic                 first_q, first_d;
  logic                 convst_q, convst_d;
  logic                 sck_q, sck_d;
  logic                 sdi_q, sdi_d;
  logic                 busy_q, busy_d;
  logic [DATA_W-1:0]    sample_q, sample_d;
  logic [CH_W-1:0]      sample_ch_q, sample_ch_d;
  logic                 sample_valid_q, sample_valid_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [AVG_CNT_W-1:0] avg_cnt_q, avg_cnt_d;
  logic [CH_W-1:0]      last_ch_q, last_ch_d;
  logic [DATA_W-1:0]    adc_value_q, adc_value_d;
  logic                 avg_valid_q, avg_valid_d;
  logic [ACC_W-1:0]     acc_base;
  logic [AVG_CNT_W-1:0] cnt_base;
  logic [ACC_W-1:0]     sum;

  // SDI bit for SCK period idx: {S/D=1, O/S, S1, S0, UNI=1, SLP=0}, then zeros.
  function automatic logic cfg_bit(input logic [CH_W-1:0] ch, input logic [BIT_W-1:0] idx);
    logic [DATA_W-1:0] word;
    word = {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0, 6'b000000};
    return word[BIT_W'(DATA_W - 1) - idx];
  endfunction

  // Frame sequencing and SPI shifting.
  always_comb begin
    state_d        = state_q;
    conv_cnt_d     = conv_cnt_q;
    div_d          = div_q;
    phase_d        = phase_q;
    bit_d          = bit_q;
    shreg_d        = shreg_q;
    ch_d           = ch_q;
    tag_ch_d       = tag_ch_q;
    first_d        = first_q;
    sdi_d          = sdi_q;
    sample_d       = sample_q;
    sample_ch_d    = sample_ch_q;
    sample_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        first_d = 1'b1;
        if (enable) begin
          state_d    = S_CONV;
          conv_cnt_d = '0;
          ch_d       = channel;
        end
      end
      S_CONV: begin
        if (conv_cnt_q == CONV_W'(CONV_CYCLES - 1)) begin
          state_d = S_SHIFT;
          div_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
          sdi_d   = cfg_bit(ch_q, '0);
        end else begin
          conv_cnt_d = conv_cnt_q + CONV_W'(1);
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            shreg_d = {shreg_q[DATA_W-2:0], adc_sdo};
          end else begin
            phase_d = 1'b0;
            if (bit_q == BIT_W'(DATA_W - 1)) begin
              // Data in this frame was converted with the previous frame's config.
              state_d  = S_DONE;
              first_d  = 1'b0;
              tag_ch_d = ch_q;
              sdi_d    = 1'b0;
              if (!first_q) begin
                sample_valid_d = 1'b1;
                sample_d       = shreg_q;
                sample_ch_d    = tag_ch_q;
              end
            end else begin
              bit_d = bit_q + BIT_W'(1);
              sdi_d = cfg_bit(ch_q, bit_q + BIT_W'(1));
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        if (enable) begin
          state_d    = S_CONV;
          conv_cnt_d = '0;
          ch_d       = channel;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    convst_d = (state_d == S_CONV);
    sck_d    = (state_d == S_SHIFT) && phase_d;
    busy_d   = (state_d != S_IDLE);
  end

  // Block averager; a channel change restarts the group.
  always_comb begin
    acc_d       = acc_q;
    avg_cnt_d   = avg_cnt_q;
    last_ch_d   = last_ch_q;
    adc_value_d = adc_value_q;
    avg_valid_d = 1'b0;
    acc_base    = acc_q;
    cnt_base    = avg_cnt_q;
    sum         = '0;

    if (sample_valid_q) begin
      if (sample_ch_q != last_ch_q) begin
        acc_base = '0;
        cnt_base = '0;
      end
      sum       = acc_base + ACC_W'(sample_q);
      last_ch_d = sample_ch_q;
      if (cnt_base == AVG_CNT_W'(AVG_N - 1)) begin
        adc_value_d = DATA_W'(sum >> AVG_LOG2);
        avg_valid_d = 1'b1;
        acc_d       = '0;
        avg_cnt_d   = '0;
      end else begin
        acc_d     = sum;
        avg_cnt_d = cnt_base + AVG_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      conv_cnt_q     <= '0;
      div_q          <= '0;
      phase_q        <= 1'b0;
      bit_q          <= '0;
      shreg_q        <= '0;
      ch_q           <= '0;
      tag_ch_q       <= '0;
      first_q        <= 1'b1;
      convst_q       <= 1'b0;
      sck_q          <= 1'b0;
      sdi_q          <= 1'b0;
      busy_q         <= 1'b0;
      sample_q       <= '0;
      sample_ch_q    <= '0;
      sample_valid_q <= 1'b0;
      acc_q          <= '0;
      avg_cnt_q      <= '0;
      last_ch_q      <= '0;
      adc_value_q    <= '0;
      avg_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      conv_cnt_q     <= conv_cnt_d;
      div_q          <= div_d;
      phase_q        <= phase_d;
      bit_q          <= bit_d;
      shreg_q        <= shreg_d;
      ch_q           <= ch_d;
      tag_ch_q       <= tag_ch_d;
      first_q        <= first_d;
      convst_q       <= convst_d;
      sck_q          <= sck_d;
      sdi_q          <= sdi_d;
      busy_q         <= busy_d;
      sample_q       <= sample_d;
      sample_ch_q    <= sample_ch_d;
      sample_valid_q <= sample_valid_d;
      acc_q          <= acc_d;
      avg_cnt_q      <= avg_cnt_d;
      last_ch_q      <= last_ch_d;
      adc_value_q    <= adc_value_d;
      avg_valid_q    <= avg_valid_d;
    end
  end

  assign adc_convst   = convst_q;
  assign adc_sck      = sck_q;
  assign adc_sdi      = sdi_q;
  assign sample       = sample_q;
  assign sample_ch    = sample_ch_q;
  assign sample_valid = sample_valid_q;
  assign adc_value    = adc_value_q;
  assign avg_valid    = avg_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_adc_ltc2308_sampler.sv
// Directed bench for adc_ltc2308_sampler with a behavioural LTC2308 SDO model.
`timescale 1ns/1ps
module tb_adc_ltc2308_sampler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  channel;
  logic        adc_convst;
  logic        adc_sck;
  logic        adc_sdi;
  logic        adc_sdo = 1'b0;
  logic [11:0] sample;
  logic [2:0]  sample_ch;
  logic        sample_valid;
  logic [11:0] adc_value;
  logic        avg_valid;
  logic        busy;

  adc_ltc2308_sampler dut (
    .clk(clk), .reset(reset), .enable(enable), .channel(channel),
    .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo),
    .sample(sample), .sample_ch(sample_ch), .sample_valid(sample_valid),
    .adc_value(adc_value), .avg_valid(avg_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: one word per frame from resp_q, MSB presented at SHIFT start.
  int unsigned resp_q[$];
  int unsigned resp_gen = 0;
  int unsigned resp_seen = 0;
  int unsigned resp_idx = 0;
  logic [11:0] adc_word = '0;
  logic        m_convst_prev = 1'b0;
  logic        m_sck_prev = 1'b0;

  always @(adc_convst or adc_sck) begin
    if (m_convst_prev && !adc_convst) begin
      if (resp_gen != resp_seen) begin
        resp_seen = resp_gen;
        resp_idx  = 0;
      end
      if (resp_idx < resp_q.size()) adc_word = 12'(resp_q[resp_idx]);
      else adc_word = 12'h000;
      resp_idx = resp_idx + 1;
      adc_sdo  = adc_word[11];
    end else if (m_sck_prev && !adc_sck) begin
      adc_word = {adc_word[10:0], 1'b0};
      adc_sdo  = adc_word[11];
    end
    m_convst_prev = adc_convst;
    m_sck_prev    = adc_sck;
  end

  // Bus monitor sampled on the falling clock edge.
  int unsigned conv_t[$];
  int unsigned rises_q[$];
  int unsigned sdi_q[$];
  int unsigned sv_s[$], sv_c[$], sv_t[$], sv_av[$];
  int unsigned av_v[$], av_t[$];
  int unsigned clr_gen = 0, clr_seen = 0;
  int unsigned rise_cnt = 0, lo_start = 0, hi_start = 0;
  int unsigned hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;
  logic [11:0] cfg_sh = '0;
  logic        convst_prev = 1'b0, sck_prev = 1'b0;

  always @(negedge clk) begin
    if (clr_gen != clr_seen) begin
      clr_seen = clr_gen;
      conv_t.delete(); rises_q.delete(); sdi_q.delete();
      sv_s.delete(); sv_c.delete(); sv_t.delete(); sv_av.delete();
      av_v.delete(); av_t.delete();
      hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
    end
    if (adc_convst && !convst_prev) begin
      if (conv_t.size() > 0) begin
        rises_q.push_back(rise_cnt);
        sdi_q.push_back(32'(cfg_sh));
      end
      conv_t.push_back(cyc);
      rise_cnt = 0;
      cfg_sh   = '0;
    end
    if (!adc_convst && convst_prev) lo_start = cyc;
    if (adc_sck && !sck_prev) begin
      if (cyc - lo_start < lo_min) lo_min = cyc - lo_start;
      if (cyc - lo_start > lo_max) lo_max = cyc - lo_start;
      hi_start = cyc;
      rise_cnt = rise_cnt + 1;
      cfg_sh   = {cfg_sh[10:0], adc_sdi};
    end
    if (!adc_sck && sck_prev) begin
      if (cyc - hi_start < hi_min) hi_min = cyc - hi_start;
      if (cyc - hi_start > hi_max) hi_max = cyc - hi_start;
      lo_start = cyc;
    end
    if (sample_valid) begin
      sv_s.push_back(32'(sample)); sv_c.push_back(32'(sample_ch));
      sv_t.push_back(cyc); sv_av.push_back(32'(adc_value));
    end
    if (avg_valid) begin
      av_v.push_back(32'(adc_value)); av_t.push_back(cyc);
    end
    convst_prev = adc_convst;
    sck_prev    = adc_sck;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned qget(input int unsigned q[$], input int unsigned i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    clr_gen++;
    tick();
  endtask

  task automatic new_resp();
    resp_q.delete();
    resp_gen++;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_convst"}, 32'(adc_convst), 0);
    check({tag, "_sck"}, 32'(adc_sck), 0);
    check({tag, "_sdi"}, 32'(adc_sdi), 0);
    check({tag, "_sample"}, 32'(sample), 0);
    check({tag, "_sample_ch"}, 32'(sample_ch), 0);
    check({tag, "_sample_valid"}, 32'(sample_valid), 0);
    check({tag, "_adc_value"}, 32'(adc_value), 0);
    check({tag, "_avg_valid"}, 32'(avg_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic wait_sv(input int unsigned n, input int unsigned budget, input string tag);
    int unsigned k = 0;
    while (sv_s.size() < n && k < budget) begin tick(); k++; end
    check(tag, 32'(sv_s.size()), n);
  endtask

  task automatic wait_av(input int unsigned n, input int unsigned budget, input string tag);
    int unsigned k = 0;
    while (av_v.size() < n && k < budget) begin tick(); k++; end
    check(tag, 32'(av_v.size()), n);
  endtask

  task automatic wait_convst(input logic lvl, input int unsigned budget, input string tag);
    int unsigned k = 0;
    while (adc_convst != lvl && k < budget) begin tick(); k++; end
    check(tag, 32'(adc_convst), 32'(lvl));
  endtask

  task automatic restart_check(input string tag, input int unsigned exp_val);
    wait_sv(1, 400, {tag, "_sv_count"});
    check({tag, "_sample"}, qget(sv_s, 0), exp_val);
    check({tag, "_first_discard_lat"}, qget(sv_t, 0) - qget(conv_t, 0), 257);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; channel = 3'd0;
    tick(3);
    check_reset_outs("por");
    reset = 1'b0;
    clear_logs();

    // Basic frame: discard, 0xABC on ch0, period, SDI word, SCK shape.
    new_resp(); resp_q.push_back('h123); resp_q.push_back('hABC);
    enable = 1'b1;
    wait_sv(1, 400, "a_sv_count");
    tick(3);
    check("a_sample", qget(sv_s, 0), 'hABC);
    check("a_sample_ch", qget(sv_c, 0), 0);
    check("a_sv_latency", qget(sv_t, 0) - qget(conv_t, 0), 257);
    check("a_period0", qget(conv_t, 1) - qget(conv_t, 0), 129);
    check("a_period1", qget(conv_t, 2) - qget(conv_t, 1), 129);
    check("a_sdi_f1", qget(sdi_q, 0), 'h880);
    check("a_sdi_f2", qget(sdi_q, 1), 'h880);
    check("a_rises_f1", qget(rises_q, 0), 12);
    check("a_rises_f2", qget(rises_q, 1), 12);
    check("a_sck_hi_min", hi_min, 2);
    check("a_sck_hi_max", hi_max, 2);
    check("a_sck_lo_min", lo_min, 2);
    check("a_sck_lo_max", lo_max, 2);
    enable = 1'b0;

    // Averaging groups: ramp, full scale, zero.
    reset = 1'b1; tick(2); reset = 1'b0;
    clear_logs();
    new_resp();
    resp_q.push_back('h0);
    resp_q.push_back(100); resp_q.push_back(101); resp_q.push_back(102); resp_q.push_back(103);
    for (int i = 0; i < 4; i++) resp_q.push_back('hFFF);
    for (int i = 0; i < 4; i++) resp_q.push_back('h000);
    enable = 1'b1;
    wait_av(3, 14 * 129 + 200, "b_av_count");
    enable = 1'b0;
    tick(300);
    check("b_avg_ramp", qget(av_v, 0), 101);
    check("b_avg_full", qget(av_v, 1), 'hFFF);
    check("b_avg_zero", qget(av_v, 2), 'h000);
    check("b_avg_latency", qget(av_t, 0) - qget(sv_t, 3), 1);
    check("b_value_before", qget(sv_av, 3), 0);
    check("b_value_hold", qget(sv_av, 5), 101);
    check("b_av_total", 32'(av_v.size()), 3);

    // Channel switch 0 -> 5 mid-stream.
    reset = 1'b1; tick(2); reset = 1'b0;
    clear_logs();
    new_resp();
    resp_q.push_back('h001); resp_q.push_back(10); resp_q.push_back(20); resp_q.push_back(30);
    resp_q.push_back(200); resp_q.push_back(204); resp_q.push_back(208); resp_q.push_back(212);
    channel = 3'd0;
    enable  = 1'b1;
    wait_sv(2, 3 * 129 + 50, "c_sv_pre_switch");
    channel = 3'd5;
    wait_av(1, 8 * 129, "c_av_count");
    enable = 1'b0;
    tick(200);
    check("c_sdi_f3", qget(sdi_q, 2), 'h880);
    check("c_sdi_f4", qget(sdi_q, 3), 'hE80);
    check("c_tag_f4", qget(sv_c, 2), 0);
    check("c_sample_f4", qget(sv_s, 2), 30);
    check("c_tag_f5", qget(sv_c, 3), 5);
    check("c_sample_f5", qget(sv_s, 3), 200);
    check("c_avg_ch5", qget(av_v, 0), 206);
    check("c_av_total", 32'(av_v.size()), 1);

    // Enable dropped during SHIFT.
    reset = 1'b1; tick(2); reset = 1'b0;
    clear_logs();
    new_resp(); resp_q.push_back('h0F0); resp_q.push_back('h555);
    enable = 1'b1;
    wait_convst(1'b1, 10, "d_f1_conv");
    wait_convst(1'b0, 200, "d_f1_shift");
    wait_convst(1'b1, 200, "d_f2_conv");
    wait_convst(1'b0, 200, "d_f2_shift");
    tick(5);
    enable = 1'b0;
    wait_sv(1, 100, "d_sv_count");
    check("d_sample", qget(sv_s, 0), 'h555);
    tick(5);
    check("d_idle_busy", 32'(busy), 0);
    check("d_idle_convst", 32'(adc_convst), 0);
    check("d_idle_sck", 32'(adc_sck), 0);
    check("d_no_new_frame", 32'(conv_t.size()), 2);

    // Reset during CONV.
    reset = 1'b1; tick(2); reset = 1'b0;
    clear_logs();
    new_resp(); resp_q.push_back('h0AA); resp_q.push_back('h111);
    enable = 1'b1;
    wait_sv(1, 400, "e_sv_pre");
    tick(10);
    check("e_in_conv", 32'(adc_convst), 1);
    reset = 1'b1;
    tick();
    check_reset_outs("e_rst");
    check("e_no_strobe", 32'(sv_s.size()), 1);
    tick();
    clear_logs();
    new_resp(); resp_q.push_back('h333); resp_q.push_back('h444);
    reset = 1'b0;
    restart_check("e_restart", 'h444);

    // Reset during SHIFT.
    wait_convst(1'b1, 10, "f_conv");
    wait_convst(1'b0, 200, "f_shift");
    tick(15);
    check("f_in_shift_busy", 32'(busy), 1);
    reset = 1'b1;
    tick();
    check_reset_outs("f_rst");
    check("f_no_strobe", 32'(sv_s.size()), 1);
    tick();
    clear_logs();
    new_resp(); resp_q.push_back('h0AA); resp_q.push_back('h555);
    reset = 1'b0;
    restart_check("f_restart", 'h555);
    enable = 1'b0;
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
